// File: rtl/cache_ctrl_4way.sv
// 4-way fully associative, one-word-per-line write-back cache controller feeding an LRU stage.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module cache_ctrl_4way #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic [3:0]        lru_victim,
    output logic [3:0]        hit,
    output logic [3:0]        wren_cache,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);

    localparam int unsigned NWAYS = 4;
    localparam int unsigned WAY_W = 2;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITEBACK,
        S_FILL,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [WAY_W-1:0]    victim_q, victim_d;
    logic [NWAYS-1:0]    valid_q, valid_d;
    logic [NWAYS-1:0]    dirty_q, dirty_d;
    logic [ADDR_W-1:0]   tag_q [NWAYS];
    logic [ADDR_W-1:0]   tag_d [NWAYS];
    logic [DATA_W-1:0]   data_q [NWAYS];
    logic [DATA_W-1:0]   data_d [NWAYS];
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [NWAYS-1:0]    match;
    logic [WAY_W-1:0]    hit_idx;
    logic [WAY_W-1:0]    victim_sel;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [WAY_W-1:0] lowest_idx(input logic [NWAYS-1:0] v);
        logic [WAY_W-1:0] idx;
        idx = '0;
        for (int i = NWAYS - 1; i >= 0; i--) begin
            if (v[i]) idx = WAY_W'(i);
        end
        return idx;
    endfunction

    // Tag compare and victim choice: prefer an empty way, else the LRU way.
    always_comb begin
        for (int i = 0; i < NWAYS; i++) begin
            match[i] = valid_q[i] && (tag_q[i] == addr_q);
        end
        hit_idx = lowest_idx(match);
        if (~valid_q != '0) victim_sel = lowest_idx(~valid_q);
        else                victim_sel = lowest_idx(lru_victim);
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        victim_d   = victim_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        tag_d      = tag_q;
        data_d     = data_q;
        rdata_d    = rdata_q;
        hit        = '0;
        wren_cache = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        cpu_ready  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                hit = match;
                if (match != '0) begin
                    if (we_q) begin
                        data_d[hit_idx]  = wdata_q;
                        dirty_d[hit_idx] = 1'b1;
                    end else begin
                        rdata_d = data_q[hit_idx];
                    end
                    state_d = S_DONE;
                end else begin
                    victim_d = victim_sel;
                    if (valid_q[victim_sel] && dirty_q[victim_sel]) state_d = S_WRITEBACK;
                    else                                            state_d = S_FILL;
                end
            end
            S_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = tag_q[victim_q];
                mem_wdata = data_q[victim_q];
                if (mem_ack) begin
                    dirty_d[victim_q] = 1'b0;
                    state_d           = S_FILL;
                end
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (mem_ack) begin
                    tag_d[victim_q]   = addr_q;
                    valid_d[victim_q] = 1'b1;
                    wren_cache        = NWAYS'(1) << victim_q;
                    if (we_q) begin
                        data_d[victim_q]  = wdata_q;
                        dirty_d[victim_q] = 1'b1;
                    end else begin
                        data_d[victim_q]  = mem_rdata;
                        dirty_d[victim_q] = 1'b0;
                        rdata_d           = mem_rdata;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                cpu_ready = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            victim_q <= '0;
            valid_q  <= '0;
            dirty_q  <= '0;
            rdata_q  <= '0;
            for (int i = 0; i < NWAYS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            victim_q <= victim_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            rdata_q  <= rdata_d;
            for (int i = 0; i < NWAYS; i++) begin
                tag_q[i]  <= tag_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign cpu_rdata = rdata_q;

`ifdef CACHE_STATS_EN
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    // Saturating lookup counters, stepped once per COMPARE cycle.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == S_COMPARE) begin
            if (match != '0) begin
                if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
            end else begin
                if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule
